// File: rtl/write_slave.sv
// write_slave: single-beat write target with per-transaction wait states,
// OKAY/SLVERR response, backdoor read port and saturating event counters.
module write_slave #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 192
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [3:0]            id,
  input  logic [3:0]            wait_cycles,
  output logic                  ready,
  output logic [1:0]            resp,
  output logic [3:0]            resp_id,
  output logic                  busy,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [15:0]           wr_count,
  output logic [15:0]           err_count
);

  localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W   = 16;
  localparam logic [1:0]  RESP_OK = 2'b00;
  localparam logic [1:0]  RESP_SE = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [3:0]             id_q, id_d;
  logic                   ready_q, ready_d;
  logic [1:0]             resp_q, resp_d;
  logic [3:0]             resp_id_q, resp_id_d;
  logic                   busy_q, busy_d;
  logic [CNT_W-1:0]       wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]       err_cnt_q, err_cnt_d;
  logic [DATA_WIDTH-1:0]  rd_data_q, rd_data_d;

  logic                   mem_we_c;
  logic [ADDR_WIDTH-1:0]  fin_addr_c;
  logic [DATA_WIDTH-1:0]  fin_data_c;
  logic [3:0]             fin_id_c;
  logic                   fin_ok_c;
  logic                   enter_resp_c;
  logic                   rd_ok_c;

  logic [DATA_WIDTH-1:0]  mem [DEPTH];

  // Transaction fields used on the RESP-entry edge: live inputs when the
  // request is accepted with zero wait states, captured copies otherwise.
  always_comb begin
    fin_addr_c = addr_q;
    fin_data_c = data_q;
    fin_id_c   = id_q;
    if (state_q == S_IDLE) begin
      fin_addr_c = addr;
      fin_data_c = data;
      fin_id_c   = id;
    end
    fin_ok_c = (32'(fin_addr_c) < 32'(DEPTH));
  end

  // Next-state, capture, response and counter logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    data_d       = data_q;
    id_d         = id_q;
    ready_d      = 1'b0;
    resp_d       = RESP_OK;
    resp_id_d    = 4'd0;
    wr_cnt_d     = wr_cnt_q;
    err_cnt_d    = err_cnt_q;
    mem_we_c     = 1'b0;
    enter_resp_c = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (valid) begin
          addr_d = addr;
          data_d = data;
          id_d   = id;
          if (wait_cycles != 4'd0) begin
            state_d = S_WAIT;
            cnt_d   = wait_cycles;
          end else begin
            cnt_d        = 4'd0;
            enter_resp_c = 1'b1;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          enter_resp_c = 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        if (!valid) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (enter_resp_c) begin
      state_d   = S_RESP;
      ready_d   = 1'b1;
      resp_id_d = fin_id_c;
      if (fin_ok_c) begin
        resp_d   = RESP_OK;
        mem_we_c = 1'b1;
        if (wr_cnt_q != 16'hFFFF) begin
          wr_cnt_d = wr_cnt_q + 16'd1;
        end
      end else begin
        resp_d = RESP_SE;
        if (err_cnt_q != 16'hFFFF) begin
          err_cnt_d = err_cnt_q + 16'd1;
        end
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  // Backdoor read: out-of-range addresses read as zero.
  always_comb begin
    rd_ok_c   = (32'(rd_addr) < 32'(DEPTH));
    rd_data_d = '0;
    if (rd_ok_c) begin
      rd_data_d = mem[rd_addr[IDX_W-1:0]];
    end
  end

  // Control, response and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      data_q    <= '0;
      id_q      <= 4'd0;
      ready_q   <= 1'b0;
      resp_q    <= RESP_OK;
      resp_id_q <= 4'd0;
      busy_q    <= 1'b0;
      wr_cnt_q  <= '0;
      err_cnt_q <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      id_q      <= id_d;
      ready_q   <= ready_d;
      resp_q    <= resp_d;
      resp_id_q <= resp_id_d;
      busy_q    <= busy_d;
      wr_cnt_q  <= wr_cnt_d;
      err_cnt_q <= err_cnt_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage array; contents survive reset, and reset suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && mem_we_c) begin
      mem[fin_addr_c[IDX_W-1:0]] <= fin_data_c;
    end
  end

  assign ready     = ready_q;
  assign resp      = resp_q;
  assign resp_id   = resp_id_q;
  assign busy      = busy_q;
  assign rd_data   = rd_data_q;
  assign wr_count  = wr_cnt_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_write_slave.sv
// Directed self-checking bench for write_slave.
module tb_write_slave;

  logic        clk;
  logic        rst;
  logic        valid;
  logic [7:0]  addr;
  logic [31:0] data;
  logic [3:0]  id;
  logic [3:0]  wait_cycles;
  logic        ready;
  logic [1:0]  resp;
  logic [3:0]  resp_id;
  logic        busy;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data;
  logic [15:0] wr_count;
  logic [15:0] err_count;

  int tests;
  int fails;

  write_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(192)) dut (
    .clk(clk), .rst(rst), .valid(valid), .addr(addr), .data(data), .id(id),
    .wait_cycles(wait_cycles), .ready(ready), .resp(resp), .resp_id(resp_id),
    .busy(busy), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_count(wr_count), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction: accept, scramble inputs, wait for ready, drop valid, return to IDLE.
  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] i,
                          input logic [3:0] w, output int lat, output logic [1:0] r,
                          output logic [3:0] rid, output int busy_lows, output int extra);
    addr = a; data = d; id = i; wait_cycles = w; valid = 1'b1;
    tick();
    addr = ~a; data = ~d; id = ~i; wait_cycles = 4'hF;
    lat = 0; busy_lows = 0; extra = 0; r = 2'b11; rid = 4'hF;
    while (!ready && lat < 40) begin
      if (!busy) busy_lows++;
      tick();
      lat++;
    end
    if (!busy) busy_lows++;
    r = resp; rid = resp_id;
    valid = 1'b0;
    tick();
    if (ready) extra++;
    tick();
    if (ready) extra++;
  endtask

  task automatic read_mem(input logic [7:0] a, output logic [31:0] d);
    rd_addr = a;
    tick();
    d = rd_data;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b0;
    tick(); tick();
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b expected 0", ready); end
    tests++; if (resp !== 2'b00) begin fails++; $display("FAIL reset_resp: got %b expected 00", resp); end
    tests++; if (resp_id !== 4'h0) begin fails++; $display("FAIL reset_resp_id: got %h expected 0", resp_id); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (wr_count !== 16'h0) begin fails++; $display("FAIL reset_wr_count: got %h expected 0", wr_count); end
    tests++; if (err_count !== 16'h0) begin fails++; $display("FAIL reset_err_count: got %h expected 0", err_count); end
    tests++; if (rd_data !== 32'h0) begin fails++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_zero_wait();
    int lat, bl, ex; logic [1:0] r; logic [3:0] rid; logic [31:0] rd;
    do_write(8'h10, 32'hDEADBEEF, 4'h3, 4'd0, lat, r, rid, bl, ex);
    tests++; if (lat !== 0) begin fails++; $display("FAIL zw_latency: got %0d expected 0", lat); end
    tests++; if (r !== 2'b00) begin fails++; $display("FAIL zw_resp: got %b expected 00", r); end
    tests++; if (rid !== 4'h3) begin fails++; $display("FAIL zw_resp_id: got %h expected 3", rid); end
    tests++; if (ex !== 0) begin fails++; $display("FAIL zw_extra_pulse: got %0d expected 0", ex); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL zw_busy_idle: got %b expected 0", busy); end
    read_mem(8'h10, rd);
    tests++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL zw_rd_data: got %h expected deadbeef", rd); end
    tests++; if (wr_count !== 16'd1) begin fails++; $display("FAIL zw_wr_count: got %0d expected 1", wr_count); end
  endtask

  task automatic test_wait5();
    int lat, bl, ex; logic [1:0] r; logic [3:0] rid; logic [31:0] rd;
    do_write(8'h20, 32'hA5A5A5A5, 4'hA, 4'd5, lat, r, rid, bl, ex);
    tests++; if (lat !== 5) begin fails++; $display("FAIL w5_latency: got %0d expected 5", lat); end
    tests++; if (bl !== 0) begin fails++; $display("FAIL w5_busy: got %0d low samples expected 0", bl); end
    tests++; if (ex !== 0) begin fails++; $display("FAIL w5_extra_pulse: got %0d expected 0", ex); end
    tests++; if (rid !== 4'hA) begin fails++; $display("FAIL w5_resp_id: got %h expected a", rid); end
    tests++; if (r !== 2'b00) begin fails++; $display("FAIL w5_resp: got %b expected 00", r); end
    read_mem(8'h20, rd);
    tests++; if (rd !== 32'hA5A5A5A5) begin fails++; $display("FAIL w5_rd_data: got %h expected a5a5a5a5", rd); end
  endtask

  task automatic test_slverr();
    int lat, bl, ex; logic [1:0] r; logic [3:0] rid; logic [31:0] rd;
    do_write(8'hC0, 32'h12345678, 4'h7, 4'd0, lat, r, rid, bl, ex);
    tests++; if (r !== 2'b10) begin fails++; $display("FAIL se_resp: got %b expected 10", r); end
    tests++; if (rid !== 4'h7) begin fails++; $display("FAIL se_resp_id: got %h expected 7", rid); end
    tests++; if (err_count !== 16'd1) begin fails++; $display("FAIL se_err_count: got %0d expected 1", err_count); end
    tests++; if (wr_count !== 16'd2) begin fails++; $display("FAIL se_wr_count: got %0d expected 2", wr_count); end
    read_mem(8'hC0, rd);
    tests++; if (rd !== 32'h0) begin fails++; $display("FAIL se_rd_oob: got %h expected 0", rd); end
    read_mem(8'h10, rd);
    tests++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL se_word10: got %h expected deadbeef", rd); end
    read_mem(8'h20, rd);
    tests++; if (rd !== 32'hA5A5A5A5) begin fails++; $display("FAIL se_word20: got %h expected a5a5a5a5", rd); end
  endtask

  task automatic test_hold_valid();
    int pulses, bl;
    addr = 8'h30; data = 32'h0BADF00D; id = 4'h5; wait_cycles = 4'd0; valid = 1'b1;
    tick();
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL hv_ready: got %b expected 1", ready); end
    pulses = 0; bl = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (ready) pulses++;
      if (!busy) bl++;
    end
    tests++; if (pulses !== 0) begin fails++; $display("FAIL hv_extra_pulses: got %0d expected 0", pulses); end
    tests++; if (bl !== 0) begin fails++; $display("FAIL hv_done_busy: got %0d low samples expected 0", bl); end
    valid = 1'b0;
    tick();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL hv_idle: got busy %b expected 0", busy); end
    tests++; if (wr_count !== 16'd3) begin fails++; $display("FAIL hv_wr_count: got %0d expected 3", wr_count); end
  endtask

  task automatic test_reset_mid();
    int lat, bl, ex, pulses; logic [1:0] r; logic [3:0] rid; logic [31:0] rd;
    do_write(8'h40, 32'h44444444, 4'h1, 4'd0, lat, r, rid, bl, ex);
    addr = 8'h40; data = 32'h99999999; id = 4'h9; wait_cycles = 4'd8; valid = 1'b1;
    tick();
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; valid = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rm_busy: got %b expected 0", busy); end
    tests++; if (wr_count !== 16'd0) begin fails++; $display("FAIL rm_wr_count: got %0d expected 0", wr_count); end
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (ready) pulses++;
    end
    tests++; if (pulses !== 0) begin fails++; $display("FAIL rm_no_pulse: got %0d expected 0", pulses); end
    read_mem(8'h40, rd);
    tests++; if (rd !== 32'h44444444) begin fails++; $display("FAIL rm_word_kept: got %h expected 44444444", rd); end
    do_write(8'h41, 32'h00000055, 4'h6, 4'd2, lat, r, rid, bl, ex);
    tests++; if (lat !== 2) begin fails++; $display("FAIL rm_new_latency: got %0d expected 2", lat); end
    tests++; if (rid !== 4'h6) begin fails++; $display("FAIL rm_new_resp_id: got %h expected 6", rid); end
    read_mem(8'h41, rd);
    tests++; if (rd !== 32'h00000055) begin fails++; $display("FAIL rm_new_word: got %h expected 00000055", rd); end
  endtask

  task automatic test_back_to_back();
    int lat, bl, ex; logic [1:0] r; logic [3:0] rid1, rid2; logic [31:0] rd;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    read_mem(8'h10, rd);
    tests++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL b2b_mem_kept: got %h expected deadbeef", rd); end
    do_write(8'h05, 32'h11111111, 4'h1, 4'd0, lat, r, rid1, bl, ex);
    do_write(8'h05, 32'h22222222, 4'h2, 4'd0, lat, r, rid2, bl, ex);
    tests++; if (rid1 !== 4'h1) begin fails++; $display("FAIL b2b_id1: got %h expected 1", rid1); end
    tests++; if (rid2 !== 4'h2) begin fails++; $display("FAIL b2b_id2: got %h expected 2", rid2); end
    read_mem(8'h05, rd);
    tests++; if (rd !== 32'h22222222) begin fails++; $display("FAIL b2b_rd_data: got %h expected 22222222", rd); end
    tests++; if (wr_count !== 16'd2) begin fails++; $display("FAIL b2b_wr_count: got %0d expected 2", wr_count); end
  endtask

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1; valid = 1'b0; addr = '0; data = '0; id = '0; wait_cycles = '0; rd_addr = '0;
    test_reset();
    test_zero_wait();
    test_wait5();
    test_slverr();
    test_hold_valid();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/write_slave.md
WRITE_SLAVE -- requirements
Module: write_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width.
REQ-003 SHALL have parameter DEPTH, default 192, number of implemented words; legal addresses 0..DEPTH-1.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port valid  input  1  master request; addr/data/id held stable while high.
REQ-007 SHALL have port addr  input  ADDR_WIDTH  write address.
REQ-008 SHALL have port data  input  DATA_WIDTH  write data.
REQ-009 SHALL have port id  input  4  transaction id.
REQ-010 SHALL have port wait_cycles  input  4  wait states inserted per transaction, sampled at acceptance.
REQ-011 SHALL have port ready  output  1  one-cycle completion strobe.
REQ-012 SHALL have port resp  output  2  response: 2'b00 OKAY, 2'b10 SLVERR; valid only while ready=1.
REQ-013 SHALL have port resp_id  output  4  id of the completing transaction; valid only while ready=1.
REQ-014 SHALL have port busy  output  1  high whenever FSM is not IDLE.
REQ-015 SHALL have port rd_addr  input  ADDR_WIDTH  backdoor read address.
REQ-016 SHALL have port rd_data  output  DATA_WIDTH  registered backdoor read data.
REQ-017 SHALL have port wr_count  output  16  OKAY writes completed, saturating.
REQ-018 SHALL have port err_count  output  16  SLVERR responses issued, saturating.

Function
REQ-019 SHALL implement FSM states IDLE, WAIT, RESP, DONE.
REQ-020 SHALL, in IDLE with valid=1 at an edge, capture addr, data, id and wait_cycles, then enter WAIT if captured wait_cycles>0, else RESP.
REQ-021 SHALL, in WAIT, decrement a wait counter each cycle and enter RESP on the edge where it reaches zero; exactly W WAIT cycles for captured value W.
REQ-022 SHALL assert ready for exactly one cycle in RESP; acceptance at edge N gives ready high in cycle N+1+W.
REQ-023 SHALL drive resp=2'b10 if captured addr>=DEPTH, else 2'b00; resp_id = captured id; both 0 while ready=0.
REQ-024 SHALL write captured data to mem[captured addr] on the edge entering RESP, only for OKAY; SLVERR leaves memory unchanged.
REQ-025 SHALL go RESP->DONE unconditionally, and DONE->IDLE on the first edge with valid=0; a request held high after ready is never accepted twice.
REQ-026 SHALL ignore changes to addr/data/id/wait_cycles after capture.
REQ-027 SHALL update rd_data <= mem[rd_addr] every edge (1-cycle latency); rd_addr>=DEPTH returns 0.
REQ-028 SHALL increment wr_count per OKAY and err_count per SLVERR, on the RESP edge, saturating at 16'hFFFF.
REQ-029 SHALL, with valid=1 continuously across back-to-back transactions, accept the next request only after passing DONE->IDLE with valid low (min 1 idle cycle between requests).

Reset
REQ-030 SHALL, on rst=1 at an edge, force IDLE, ready=0, resp=0, resp_id=0, busy=0, wait counter=0, wr_count=0, err_count=0, rd_data=0.
REQ-031 SHALL not clear memory contents on reset.
REQ-032 SHALL abandon any in-flight transaction on reset mid-operation: no ready pulse, no memory write if reset precedes the RESP-entry edge.

Verification
REQ-033 SHALL cover: wait_cycles=0, addr=8'h10, data=32'hDEADBEEF, id=4'h3 -> ready one cycle after acceptance, resp=00, resp_id=3, rd_data at 8'h10 = DEADBEEF, wr_count=1.
REQ-034 SHALL cover: wait_cycles=5, addr=8'h20, id=4'hA -> ready exactly 6 cycles after acceptance edge, busy high throughout, single pulse.
REQ-035 SHALL cover: addr=8'hC0 (=DEPTH), data=32'h12345678 -> resp=10, err_count=1, backdoor read 8'hC0 returns 0, no word modified.
REQ-036 SHALL cover: valid held high 10 cycles after ready, wait_cycles=0 -> exactly one ready pulse, FSM in DONE until valid drops.
REQ-037 SHALL cover: rst asserted in WAIT (wait_cycles=8, 3 cycles in) -> no ready pulse, target word unchanged, busy=0 next cycle, new request then completes normally.
REQ-038 SHALL cover: two back-to-back writes to 8'h05 (11111111 then 22222222, ids 1,2) -> resp_ids 1 then 2, final rd_data 22222222, wr_count=2.
